// File: rtl/uart_rx_deser.sv
// uart_rx_deser -- UART receive deserializer.
//
// Oversamples an asynchronous serial line, detects the start bit on a falling
// edge, samples data/parity/stop bits at their centres and hands each good
// frame to a downstream FIFO as one DATA_WIDTH word over valid/ready.
// Framing, parity and overrun errors are reported as single-cycle pulses.
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   baud_div      clocks per oversample tick minus 1 (latched at each start bit)
//   rx_i          serial line, asynchronous, idle high
//   data_o        received word, stable while valid_out is high
//   valid_out     data_o holds an unconsumed word
//   ready_out     downstream accepts the word
//   frame_err_o   pulse: stop bit sampled low
//   parity_err_o  pulse: parity mismatch
//   overrun_o     pulse: good frame lost because the output was still occupied

module uart_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_TICK   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_TICK   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);
  localparam logic             PAR_ODD_BIT = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_d;

  logic rx_meta, rx_s, rx_prev;
  logic fall, start_det;

  logic [DIV_WIDTH-1:0]  baud_div_q;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic                  tick;
  logic [CNT_W-1:0]      tick_cnt;
  logic                  sample;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bad;
  logic                  stop_done;
  logic                  good;

  // Two-flop synchronizer plus one stage of history for edge detection.
  // Idle level is high, so all three reset to 1 to avoid a false start.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall      = rx_prev & ~rx_s;
  assign start_det = (state == IDLE) & fall;

  // Oversample tick generator. Restarting it at the start edge pins the
  // sampling phase to the edge itself rather than to a free-running divider.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_div_q <= '0;
      div_cnt    <= '0;
    end else if (start_det) begin
      baud_div_q <= baud_div;
      div_cnt    <= '0;
    end else if (tick) begin
      div_cnt    <= '0;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == baud_div_q);

  // Sample strobe: half a bit into the start bit, then one full bit period
  // per following bit, which lands every later sample on a bit centre.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sample = 1'b0;
    if (tick) begin
      case (state)
        START:             sample = (tick_cnt == HALF_TICK);
        DATA, PARITY, STOP: sample = (tick_cnt == LAST_TICK);
        default:           sample = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (fall)   state_d = START;
      START:  if (sample) state_d = rx_s ? IDLE : DATA;   // high here = glitch
      DATA:   if (sample && bit_cnt == LAST_BIT)
                state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (sample) state_d = STOP;
      STOP:   if (sample) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
    end else if (state == IDLE || sample) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Frame datapath: LSB arrives first, so shifting right with the new bit in
  // the MSB leaves the word correctly aligned after DATA_WIDTH samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (start_det) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end
      if (state == DATA && sample) begin
        shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == PARITY && sample) begin
        par_bad <= rx_s ^ (^shift) ^ PAR_ODD_BIT;
      end
    end
  end

  // Completion outcome, in priority order: framing, parity, deliver/overrun.
  assign stop_done = (state == STOP) & sample;
  assign good      = stop_done & rx_s & ~par_bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_o       <= '0;
      valid_out    <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o  <= stop_done & ~rx_s;
      parity_err_o <= stop_done & rx_s & par_bad;
      overrun_o    <= good & valid_out & ~ready_out;
      // A word being taken this cycle frees the register, so a new word can
      // replace it with no bubble in valid_out.
      if (good && (!valid_out || ready_out)) begin
        data_o    <= shift;
        valid_out <= 1'b1;
      end else if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
